// File: rtl/bp_fpga_host_nbf_deframer.sv
// Reassembles a UART byte stream into fixed-width NBF packets {data, addr, opcode}.
// Optional trailing XOR checksum, header-only control opcodes and inter-byte timeout.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an opcode byte; running XOR and index cleared
// ADDR   | collecting address bytes, LSB first
// DATA   | collecting data bytes, LSB first
// CSUM   | waiting for the XOR checksum byte
// FULL   | packet presented on nbf_o until the consumer takes it
module bp_fpga_host_nbf_deframer #(
  parameter int nbf_addr_width_p = 40,
  parameter int nbf_data_width_p = 64,
  parameter int checksum_p       = 0,
  parameter int short_ctrl_p     = 0,
  parameter int timeout_cycles_p = 0,
  localparam int nbf_width_lp    = 8 + nbf_addr_width_p + nbf_data_width_p
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [7:0]              byte_i,
  input  logic                    byte_v_i,
  output logic                    byte_ready_and_o,
  output logic [nbf_width_lp-1:0] nbf_o,
  output logic                    nbf_v_o,
  input  logic                    nbf_ready_and_i,
  output logic                    error_o,
  input  logic                    error_clr_i,
  output logic [15:0]             pkt_count_o
);

  localparam int addr_bytes_lp = nbf_addr_width_p / 8;
  localparam int data_bytes_lp = nbf_data_width_p / 8;
  localparam int max_bytes_lp  = (addr_bytes_lp > data_bytes_lp) ? addr_bytes_lp : data_bytes_lp;
  localparam int idx_width_lp  = $clog2(max_bytes_lp) + 1;
  localparam int tmo_width_lp  = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;

  localparam logic [idx_width_lp-1:0] addr_last_lp = idx_width_lp'(addr_bytes_lp - 1);
  localparam logic [idx_width_lp-1:0] data_last_lp = idx_width_lp'(data_bytes_lp - 1);
  localparam logic [tmo_width_lp-1:0] tmo_load_lp  =
    tmo_width_lp'((timeout_cycles_p > 0) ? timeout_cycles_p - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_FULL = 3'd4
  } state_e;

  state_e                      state_r, state_n;
  logic [7:0]                  opcode_r;
  logic [nbf_addr_width_p-1:0] addr_r;
  logic [nbf_data_width_p-1:0] data_r;
  logic [idx_width_lp-1:0]     idx_r;
  logic [7:0]                  xor_r;
  logic [tmo_width_lp-1:0]     tmo_r;
  logic                        error_r;
  logic [15:0]                 pkt_count_r;

  logic byte_accept, deliver, header_only, pkt_active, tmo_hit, csum_bad;

  assign byte_ready_and_o = (state_r != S_FULL);
  assign nbf_v_o          = (state_r == S_FULL);
  assign byte_accept      = byte_v_i & byte_ready_and_o;
  assign deliver          = nbf_v_o & nbf_ready_and_i;
  assign header_only      = (short_ctrl_p != 0) && (byte_i[7:4] == 4'hF);
  assign pkt_active       = (state_r == S_ADDR) || (state_r == S_DATA) || (state_r == S_CSUM);
  // Down-counter reaches zero on the last allowed idle cycle.
  assign tmo_hit          = (timeout_cycles_p != 0) && pkt_active && !byte_accept && (tmo_r == '0);
  assign csum_bad         = (state_r == S_CSUM) && byte_accept && (byte_i != xor_r);

  assign nbf_o       = {data_r, addr_r, opcode_r};
  assign error_o     = error_r;
  assign pkt_count_o = pkt_count_r;

  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (byte_accept) begin
          if (header_only) state_n = (checksum_p != 0) ? S_CSUM : S_FULL;
          else             state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        if (tmo_hit) state_n = S_IDLE;
        else if (byte_accept && (idx_r == addr_last_lp)) state_n = S_DATA;
      end
      S_DATA: begin
        if (tmo_hit) state_n = S_IDLE;
        else if (byte_accept && (idx_r == data_last_lp))
          state_n = (checksum_p != 0) ? S_CSUM : S_FULL;
      end
      S_CSUM: begin
        if (tmo_hit) state_n = S_IDLE;
        else if (byte_accept) state_n = csum_bad ? S_IDLE : S_FULL;
      end
      S_FULL: begin
        if (nbf_ready_and_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= S_IDLE;
    else            state_r <= state_n;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_r <= '0;
    end else if (state_n != state_r) begin
      idx_r <= '0;
    end else if (byte_accept && ((state_r == S_ADDR) || (state_r == S_DATA))) begin
      idx_r <= idx_r + idx_width_lp'(1);
    end
  end

  // Fields shift in from the top so the first byte ends up in the LSBs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      opcode_r <= '0;
      addr_r   <= '0;
      data_r   <= '0;
      xor_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (byte_accept) begin
            opcode_r <= byte_i;
            addr_r   <= '0;
            data_r   <= '0;
            xor_r    <= byte_i;
          end else begin
            xor_r    <= '0;
          end
        end
        S_ADDR: begin
          if (byte_accept) begin
            addr_r <= (addr_r >> 8) | (nbf_addr_width_p'(byte_i) << (nbf_addr_width_p - 8));
            xor_r  <= xor_r ^ byte_i;
          end
        end
        S_DATA: begin
          if (byte_accept) begin
            data_r <= (data_r >> 8) | (nbf_data_width_p'(byte_i) << (nbf_data_width_p - 8));
            xor_r  <= xor_r ^ byte_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tmo_r <= tmo_load_lp;
    end else if (!pkt_active || byte_accept) begin
      tmo_r <= tmo_load_lp;
    end else if (tmo_r != '0) begin
      tmo_r <= tmo_r - tmo_width_lp'(1);
    end
  end

  // A new error event wins over a coincident clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)              error_r <= 1'b0;
    else if (tmo_hit || csum_bad) error_r <= 1'b1;
    else if (error_clr_i)        error_r <= 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   pkt_count_r <= '0;
    else if (deliver) pkt_count_r <= pkt_count_r + 16'd1;
  end

endmodule

// File: tb/tb_bp_fpga_host_nbf_deframer.sv
// Directed bench for the NBF deframer: defaults, checksum, and short-ctrl+timeout builds
// driven side by side from a vector table plus hand-written corner sequences.
module tb_bp_fpga_host_nbf_deframer;

  logic        clk, rst_n;
  logic [7:0]  byte_i    [3];
  logic        byte_v_i  [3];
  logic        rdy       [3];
  logic [111:0] nbf      [3];
  logic        nbf_v     [3];
  logic        nbf_ready [3];
  logic        err       [3];
  logic        err_clr   [3];
  logic [15:0] cnt       [3];
  logic [15:0] cnt_exp   [3];

  int n_vec, n_err;

  // 0: defaults, 1: checksum, 2: short control opcodes + 100-cycle timeout
  bp_fpga_host_nbf_deframer u_def (
    .clk_i(clk), .reset_n_i(rst_n), .byte_i(byte_i[0]), .byte_v_i(byte_v_i[0]),
    .byte_ready_and_o(rdy[0]), .nbf_o(nbf[0]), .nbf_v_o(nbf_v[0]),
    .nbf_ready_and_i(nbf_ready[0]), .error_o(err[0]), .error_clr_i(err_clr[0]),
    .pkt_count_o(cnt[0]));

  bp_fpga_host_nbf_deframer #(.checksum_p(1)) u_cs (
    .clk_i(clk), .reset_n_i(rst_n), .byte_i(byte_i[1]), .byte_v_i(byte_v_i[1]),
    .byte_ready_and_o(rdy[1]), .nbf_o(nbf[1]), .nbf_v_o(nbf_v[1]),
    .nbf_ready_and_i(nbf_ready[1]), .error_o(err[1]), .error_clr_i(err_clr[1]),
    .pkt_count_o(cnt[1]));

  bp_fpga_host_nbf_deframer #(.short_ctrl_p(1), .timeout_cycles_p(100)) u_st (
    .clk_i(clk), .reset_n_i(rst_n), .byte_i(byte_i[2]), .byte_v_i(byte_v_i[2]),
    .byte_ready_and_o(rdy[2]), .nbf_o(nbf[2]), .nbf_v_o(nbf_v[2]),
    .nbf_ready_and_i(nbf_ready[2]), .error_o(err[2]), .error_clr_i(err_clr[2]),
    .pkt_count_o(cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   dut;
    logic [4:0]   n;
    logic [127:0] bytes;     // byte k of the stream at bits [8k+7:8k]
    logic         exp_v;
    logic [111:0] exp_nbf;
    logic         exp_err;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    @(negedge clk);
    byte_i[d]   = b;
    byte_v_i[d] = 1'b1;
    for (int k = 0; k < 300 && !rdy[d]; k++) @(negedge clk);
    if (!rdy[d]) begin
      n_vec++;
      n_err++;
      $display("FAIL send_byte: dut %0d never ready, byte %0h", d, b);
    end
    @(posedge clk);
    #1 byte_v_i[d] = 1'b0;
  endtask

  task automatic handshake(input int d);
    nbf_ready[d] = 1'b1;
    @(posedge clk);
    #1 nbf_ready[d] = 1'b0;
  endtask

  task automatic clear_err(input int d);
    err_clr[d] = 1'b1;
    @(posedge clk);
    #1 err_clr[d] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [111:0] PKT_A = 112'h8877665544332211_0080001000_02;
  localparam logic [111:0] PKT_B = 112'h8796a5b4c3d2e1f0_0504030201_03;

  task automatic send_pkt(input int d, input logic [111:0] p);
    for (int k = 0; k < 14; k++) send_byte(d, p[k*8 +: 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    n_vec = 0;
    n_err = 0;
    for (int d = 0; d < 3; d++) begin
      byte_i[d] = '0; byte_v_i[d] = 1'b0; nbf_ready[d] = 1'b0; err_clr[d] = 1'b0;
      cnt_exp[d] = '0;
    end

    vecs[0] = '{2'd0, 5'd14, {16'h0, PKT_A}, 1'b1, PKT_A, 1'b0};
    vecs[1] = '{2'd0, 5'd14, {16'h0, PKT_B}, 1'b1, PKT_B, 1'b0};
    vecs[2] = '{2'd0, 5'd14, 128'h0000_0000000000000000_5544332211_ff, 1'b1,
                112'h0000000000000000_5544332211_ff, 1'b0};
    vecs[3] = '{2'd1, 5'd15, {8'h00, 8'h1b, PKT_A}, 1'b0, 112'h0, 1'b1};
    vecs[4] = '{2'd1, 5'd15, {8'h00, 8'h1a, PKT_A}, 1'b1, PKT_A, 1'b0};
    vecs[5] = '{2'd2, 5'd1,  128'hff, 1'b1, 112'hff, 1'b0};
    vecs[6] = '{2'd2, 5'd14, 128'h0000_1122334455667788_a1b2c3d4e5_ef, 1'b1,
                112'h1122334455667788_a1b2c3d4e5_ef, 1'b0};
    vecs[7] = '{2'd2, 5'd1,  128'hf0, 1'b1, 112'hf0, 1'b0};
    vecs[8] = '{2'd2, 5'd1,  128'hf5, 1'b1, 112'hf5, 1'b0};

    // Reset: asserted away from a clock edge, checked while held and after release.
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #4;
    for (int d = 0; d < 3; d++) begin
      check("rst nbf_v", 128'(nbf_v[d]), 128'(0));
      check("rst error", 128'(err[d]), 128'(0));
      check("rst count", 128'(cnt[d]), 128'(0));
      check("rst nbf", 128'(nbf[d]), 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    for (int d = 0; d < 3; d++) check("rst ready", 128'(rdy[d]), 128'(1));

    for (int i = 0; i < NV; i++) begin
      int d;
      d = int'(vecs[i].dut);
      for (int k = 0; k < int'(vecs[i].n); k++) send_byte(d, vecs[i].bytes[k*8 +: 8]);
      check($sformatf("vec%0d nbf_v", i), 128'(nbf_v[d]), 128'(vecs[i].exp_v));
      check($sformatf("vec%0d error", i), 128'(err[d]), 128'(vecs[i].exp_err));
      if (vecs[i].exp_v) begin
        check($sformatf("vec%0d nbf", i), 128'(nbf[d]), 128'(vecs[i].exp_nbf));
        handshake(d);
        cnt_exp[d] = cnt_exp[d] + 16'd1;
        check($sformatf("vec%0d nbf_v drop", i), 128'(nbf_v[d]), 128'(0));
      end
      check($sformatf("vec%0d count", i), 128'(cnt[d]), 128'(cnt_exp[d]));
      if (vecs[i].exp_err) begin
        clear_err(d);
        check($sformatf("vec%0d error clr", i), 128'(err[d]), 128'(0));
      end
    end

    // Backpressure: 50 stalled cycles with the packet held, then exactly one delivery.
    send_pkt(0, PKT_B);
    for (int c = 0; c < 50; c++) begin
      ok = nbf_v[0] && (nbf[0] == PKT_B) && !rdy[0];
      check("bp hold", 128'(ok), 128'(1));
      idle_cycles(1);
    end
    handshake(0);
    cnt_exp[0] = cnt_exp[0] + 16'd1;
    idle_cycles(3);
    check("bp nbf_v after", 128'(nbf_v[0]), 128'(0));
    check("bp count", 128'(cnt[0]), 128'(cnt_exp[0]));
    check("bp ready after", 128'(rdy[0]), 128'(1));

    // Timeout: opcode + 3 addr bytes, then silence; fires on the 100th idle cycle.
    send_byte(2, 8'h02);
    send_byte(2, 8'h00);
    send_byte(2, 8'h10);
    send_byte(2, 8'h00);
    idle_cycles(99);
    check("tmo early", 128'(err[2]), 128'(0));
    idle_cycles(1);
    check("tmo fired", 128'(err[2]), 128'(1));
    check("tmo nbf_v", 128'(nbf_v[2]), 128'(0));
    clear_err(2);
    check("tmo clr", 128'(err[2]), 128'(0));
    send_pkt(2, PKT_A);
    check("tmo next nbf_v", 128'(nbf_v[2]), 128'(1));
    check("tmo next nbf", 128'(nbf[2]), 128'(PKT_A));
    // Timer stays quiet while the packet waits in FULL.
    idle_cycles(150);
    check("tmo full nbf_v", 128'(nbf_v[2]), 128'(1));
    check("tmo full error", 128'(err[2]), 128'(0));
    handshake(2);
    cnt_exp[2] = cnt_exp[2] + 16'd1;
    check("tmo count", 128'(cnt[2]), 128'(cnt_exp[2]));
    idle_cycles(150);
    check("tmo idle error", 128'(err[2]), 128'(0));

    // Checksum error coinciding with error_clr_i: the set wins.
    for (int k = 0; k < 14; k++) send_byte(1, PKT_A[k*8 +: 8]);
    err_clr[1] = 1'b1;
    send_byte(1, 8'h00);
    err_clr[1] = 1'b0;
    check("set+clr error", 128'(err[1]), 128'(1));
    check("set+clr nbf_v", 128'(nbf_v[1]), 128'(0));
    check("set+clr count", 128'(cnt[1]), 128'(cnt_exp[1]));
    clear_err(1);
    check("set+clr cleared", 128'(err[1]), 128'(0));

    // Counter wrap, preloaded close to the top.
    @(negedge clk);
    force u_st.pkt_count_r = 16'hfffe;
    @(negedge clk);
    release u_st.pkt_count_r;
    cnt_exp[2] = 16'hfffe;
    #1 check("wrap preload", 128'(cnt[2]), 128'(cnt_exp[2]));
    send_byte(2, 8'hff);
    handshake(2);
    check("wrap ffff", 128'(cnt[2]), 128'(16'hffff));
    send_byte(2, 8'hff);
    handshake(2);
    check("wrap 0000", 128'(cnt[2]), 128'(16'h0000));

    // Reset in the middle of a packet discards it.
    send_byte(0, 8'h02);
    send_byte(0, 8'h00);
    send_byte(0, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst nbf_v", 128'(nbf_v[0]), 128'(0));
    check("mid rst count", 128'(cnt[0]), 128'(0));
    check("mid rst nbf", 128'(nbf[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    check("mid rst ready", 128'(rdy[0]), 128'(1));
    check("mid rst no out", 128'(nbf_v[0]), 128'(0));
    send_pkt(0, PKT_B);
    check("mid rst next nbf_v", 128'(nbf_v[0]), 128'(1));
    check("mid rst next nbf", 128'(nbf[0]), 128'(PKT_B));
    handshake(0);
    check("mid rst next count", 128'(cnt[0]), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
